// File: rtl/mips_isa_pkg.sv
// mips_isa_pkg: shared op enum, MIPS opcode/funct constants, loader state type and packing helpers.
package mips_isa_pkg;
  typedef enum logic [4:0] {
    OP_NOP, OP_ADD, OP_ADDU, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLL, OP_MUL,
    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLTZ, OP_BGEZ,
    OP_BGTZ, OP_J
  } op_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WRITE, S_DONE} state_e;
  localparam logic [5:0] OPC_RTYPE  = 6'd0;
  localparam logic [5:0] OPC_REGIMM = 6'd1;
  localparam logic [5:0] OPC_J      = 6'd2;
  localparam logic [5:0] OPC_BEQ    = 6'd4;
  localparam logic [5:0] OPC_BNE    = 6'd5;
  localparam logic [5:0] OPC_BGTZ   = 6'd7;
  localparam logic [5:0] OPC_ADDI   = 6'd8;
  localparam logic [5:0] OPC_ADDIU  = 6'd9;
  localparam logic [5:0] OPC_ANDI   = 6'd12;
  localparam logic [5:0] OPC_ORI    = 6'd13;
  localparam logic [5:0] OPC_MUL    = 6'd28;
  localparam logic [5:0] OPC_LW     = 6'd35;
  localparam logic [5:0] OPC_SW     = 6'd43;
  localparam logic [5:0] FN_SLL     = 6'd0;
  localparam logic [5:0] FN_MUL     = 6'd2;
  localparam logic [5:0] FN_ADD     = 6'd32;
  localparam logic [5:0] FN_ADDU    = 6'd33;
  localparam logic [5:0] FN_SUB     = 6'd34;
  localparam logic [5:0] FN_AND     = 6'd36;
  localparam logic [5:0] FN_OR      = 6'd37;
  localparam logic [5:0] FN_NOR     = 6'd39;
  localparam logic [5:0] FN_SLT     = 6'd42;
  localparam logic [4:0] RT_BLTZ    = 5'd0;
  localparam logic [4:0] RT_BGEZ    = 5'd1;

  function automatic logic [31:0] enc_r(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {opc, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction
endpackage

// File: rtl/inst_encoder.sv
// inst_encoder: combinational packing of one op into a MIPS instruction word.
module inst_encoder
  import mips_isa_pkg::*;
(
  input  logic [4:0]  i_opcode,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_unsupported
);
  always_comb begin
    o_word = '0;
    o_unsupported = 1'b0;
    case (i_opcode)
      OP_NOP:   o_word = '0;
      OP_ADD:   o_word = enc_r(OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_ADD);
      OP_ADDU:  o_word = enc_r(OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_ADDU);
      OP_SUB:   o_word = enc_r(OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SUB);
      OP_AND:   o_word = enc_r(OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_AND);
      OP_OR:    o_word = enc_r(OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_OR);
      OP_NOR:   o_word = enc_r(OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_NOR);
      OP_SLT:   o_word = enc_r(OPC_RTYPE, i_rs, i_rt, i_rd, 5'd0, FN_SLT);
      OP_SLL:   o_word = enc_r(OPC_RTYPE, i_rs, i_rt, i_rd, i_shamt, FN_SLL);
      OP_MUL:   o_word = enc_r(OPC_MUL, i_rs, i_rt, i_rd, 5'd0, FN_MUL);
      OP_ADDI:  o_word = enc_i(OPC_ADDI, i_rs, i_rt, i_imm);
      OP_ADDIU: o_word = enc_i(OPC_ADDIU, i_rs, i_rt, i_imm);
      OP_ANDI:  o_word = enc_i(OPC_ANDI, i_rs, i_rt, i_imm);
      OP_ORI:   o_word = enc_i(OPC_ORI, i_rs, i_rt, i_imm);
      OP_LW:    o_word = enc_i(OPC_LW, i_rs, i_rt, i_imm);
      OP_SW:    o_word = enc_i(OPC_SW, i_rs, i_rt, i_imm);
      OP_BEQ:   o_word = enc_i(OPC_BEQ, i_rs, i_rt, i_imm);
      OP_BNE:   o_word = enc_i(OPC_BNE, i_rs, i_rt, i_imm);
      OP_BLTZ:  o_word = enc_i(OPC_REGIMM, i_rs, RT_BLTZ, i_imm);
      OP_BGEZ:  o_word = enc_i(OPC_REGIMM, i_rs, RT_BGEZ, i_imm);
      OP_BGTZ:  o_word = enc_i(OPC_BGTZ, i_rs, 5'd0, i_imm);
      OP_J:     o_word = {OPC_J, i_target};
      default:  o_unsupported = 1'b1;
    endcase
  end
endmodule

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: accepts ops over valid/ready, encodes them and writes words to instruction memory.
// Optional ENC_CHECKSUM_EN adds an XOR checksum of every acknowledged word.
module inst_encoder_loader
  import mips_isa_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [31:0] i_base_addr,
  input  logic        i_op_valid,
  output logic        o_op_ready,
  input  logic [4:0]  i_opcode,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  input  logic        i_op_last,
  output logic        o_imem_write,
  input  logic        i_imem_ack,
  output logic [31:0] o_imem_addr,
  output logic [31:0] o_imem_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
`ifdef ENC_CHECKSUM_EN
  output logic [31:0] o_checksum,
`endif
  output logic [15:0] o_count
);
  state_e      r_state, w_next;
  logic [31:0] r_addr, r_data, w_word;
  logic [15:0] r_count;
  logic        r_last, r_error, w_unsup, w_start, w_accept, w_ack;

  inst_encoder u_enc (
    .i_opcode(i_opcode), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
    .i_imm(i_imm), .i_target(i_target), .o_word(w_word), .o_unsupported(w_unsup)
  );

  assign w_start  = (r_state == S_IDLE) && i_start;
  assign w_accept = (r_state == S_RUN) && i_op_valid;
  assign w_ack    = (r_state == S_WRITE) && i_imem_ack;

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = i_start ? S_RUN : S_IDLE;
      S_RUN:   w_next = i_op_valid ? S_WRITE : S_RUN;
      S_WRITE: w_next = !i_imem_ack ? S_WRITE : r_last ? S_DONE : S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_op_ready   = r_state == S_RUN;
    o_busy       = (r_state == S_RUN) || (r_state == S_WRITE);
    o_done       = r_state == S_DONE;
    o_imem_write = r_state == S_WRITE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_last  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr  <= i_base_addr & 32'hFFFF_FFFC;
        r_count <= '0;
        r_error <= 1'b0;
      end
      if (w_accept) begin
        r_data <= w_word;
        r_last <= i_op_last;
        if (w_unsup) r_error <= 1'b1;
      end
      if (w_ack) begin
        r_addr  <= r_addr + 32'd4;
        r_count <= r_count + {15'd0, r_count != 16'hFFFF};
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] r_checksum;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_checksum <= '0;
    else if (w_start) r_checksum <= '0;
    else if (w_ack) r_checksum <= r_checksum ^ r_data;
  assign o_checksum = r_checksum;
`endif

  assign o_imem_addr = r_addr;
  assign o_imem_data = r_data;
  assign o_error     = r_error;
  assign o_count     = r_count;
endmodule

// File: tb/tb_inst_encoder_loader.sv
// tb_inst_encoder_loader: directed self-checking bench for inst_encoder_loader.
module tb_inst_encoder_loader;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_start = 1'b0, i_op_valid = 1'b0, i_op_last = 1'b0, i_imem_ack = 1'b0;
  logic [31:0] i_base_addr = '0;
  logic [4:0]  i_opcode = '0, i_rs = '0, i_rt = '0, i_rd = '0, i_shamt = '0;
  logic [15:0] i_imm = '0;
  logic [25:0] i_target = '0;
  logic        o_op_ready, o_imem_write, o_busy, o_done, o_error;
  logic [31:0] o_imem_addr, o_imem_data;
  logic [15:0] o_count;
`ifdef ENC_CHECKSUM_EN
  logic [31:0] o_checksum;
`endif
  int total = 0, bad = 0;

  typedef struct {
    logic [4:0] op, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp;
  } vec_t;
  vec_t v[9];

  inst_encoder_loader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_base_addr(i_base_addr),
    .i_op_valid(i_op_valid), .o_op_ready(o_op_ready), .i_opcode(i_opcode), .i_rs(i_rs),
    .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt), .i_imm(i_imm), .i_target(i_target),
    .i_op_last(i_op_last), .o_imem_write(o_imem_write), .i_imem_ack(i_imem_ack),
    .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data), .o_busy(o_busy), .o_done(o_done),
    .o_error(o_error),
`ifdef ENC_CHECKSUM_EN
    .o_checksum(o_checksum),
`endif
    .o_count(o_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [31:0] base);
    i_start = 1'b1;
    i_base_addr = base;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [15:0] imm, input logic [25:0] tgt, input logic last);
    int n = 0;
    {i_opcode, i_rs, i_rt, i_rd, i_shamt, i_imm, i_target, i_op_last} = {op, rs, rt, rd, sh, imm, tgt, last};
    i_op_valid = 1'b1;
    while (!o_op_ready && n < 20) begin
      @(negedge i_clk);
      n++;
    end
    check("op_ready", {31'd0, o_op_ready}, 32'd1);
    @(negedge i_clk);
    i_op_valid = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] data, input logic [31:0] addr);
    check({tag, "_wr"}, {31'd0, o_imem_write}, 32'd1);
    check({tag, "_data"}, o_imem_data, data);
    check({tag, "_addr"}, o_imem_addr, addr);
  endtask

  task automatic ack();
    i_imem_ack = 1'b1;
    @(negedge i_clk);
    i_imem_ack = 1'b0;
  endtask

  initial begin
    v[0] = '{5'd19, 5'd4,  5'd9, 5'd0, 5'd0, 16'hFFFE, 26'd0,     32'h0481FFFE};
    v[1] = '{5'd14, 5'd29, 5'd8, 5'd5, 5'd0, 16'h0004, 26'd0,     32'h8FA80004};
    v[2] = '{5'd9,  5'd1,  5'd2, 5'd3, 5'd7, 16'h0000, 26'd0,     32'h70221802};
    v[3] = '{5'd18, 5'd4,  5'd9, 5'd0, 5'd0, 16'h0008, 26'd0,     32'h04800008};
    v[4] = '{5'd20, 5'd4,  5'd9, 5'd0, 5'd0, 16'h0008, 26'd0,     32'h1C800008};
    v[5] = '{5'd8,  5'd0,  5'd2, 5'd4, 5'd3, 16'h0000, 26'd0,     32'h000220C0};
    v[6] = '{5'd13, 5'd1,  5'd2, 5'd7, 5'd0, 16'h1234, 26'd0,     32'h34221234};
    v[7] = '{5'd15, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0,     32'hAFA80004};
    v[8] = '{5'd21, 5'd3,  5'd0, 5'd0, 5'd0, 16'h0000, 26'h10,    32'h08000010};

    repeat (2) @(negedge i_clk);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_ready", {31'd0, o_op_ready}, 32'd0);
    check("rst_write", {31'd0, o_imem_write}, 32'd0);
    check("rst_addr", o_imem_addr, 32'd0);
    check("rst_count", {16'd0, o_count}, 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Session 1: ADD with junk in unused fields, then stalled ADDI as last op
    start(32'h100);
    check("s1_busy", {31'd0, o_busy}, 32'd1);
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd9, 16'hFFFF, 26'h3FFFFFF, 1'b0);
    expect_write("add", 32'h00221820, 32'h100);
    ack();
    check("s1_count1", {16'd0, o_count}, 32'd1);
    send(5'd10, 5'd0, 5'd5, 5'd7, 5'd3, 16'h0010, 26'h1234, 1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_write("addi_stall", 32'h20050010, 32'h104);
      check("addi_stall_ready", {31'd0, o_op_ready}, 32'd0);
      @(negedge i_clk);
    end
    ack();
    check("s1_done", {31'd0, o_done}, 32'd1);
    check("s1_busy_done", {31'd0, o_busy}, 32'd0);
    check("s1_count2", {16'd0, o_count}, 32'd2);
`ifdef ENC_CHECKSUM_EN
    check("s1_checksum", o_checksum, 32'h20271830);
`endif
    @(negedge i_clk);
    check("s1_done_pulse", {31'd0, o_done}, 32'd0);

    // Session 2: encoding table, base low bits masked
    start(32'h203);
    check("s2_count_clr", {16'd0, o_count}, 32'd0);
    for (int i = 0; i < 9; i++) begin
      send(v[i].op, v[i].rs, v[i].rt, v[i].rd, v[i].sh, v[i].imm, v[i].tgt, i == 8);
      expect_write($sformatf("vec%0d", i), v[i].exp, 32'h200 + 32'(i * 4));
      ack();
    end
    check("s2_done", {31'd0, o_done}, 32'd1);
    check("s2_count", {16'd0, o_count}, 32'd9);
    @(negedge i_clk);
    check("s2_done_pulse", {31'd0, o_done}, 32'd0);

    // Session 3: unsupported op and address wrap
    start(32'hFFFFFFFC);
    send(5'd25, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'h2AAAAAA, 1'b0);
    expect_write("unsup", 32'h0, 32'hFFFFFFFC);
    check("unsup_err", {31'd0, o_error}, 32'd1);
    ack();
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'h2AAAAAA, 1'b1);
    expect_write("wrap_nop", 32'h0, 32'h0);
    ack();
    @(negedge i_clk);
    check("err_sticky", {31'd0, o_error}, 32'd1);
    start(32'h40);
    check("err_clr", {31'd0, o_error}, 32'd0);

    // Session 4: reset while a write is pending
    send(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 1'b0);
    expect_write("pre_rst", 32'h00221820, 32'h40);
    #2 i_rst_n = 1'b0;
    #1;
    check("mid_rst_write", {31'd0, o_imem_write}, 32'd0);
    check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    check("mid_rst_ready", {31'd0, o_op_ready}, 32'd0);
    check("mid_rst_done", {31'd0, o_done}, 32'd0);
    check("mid_rst_addr", o_imem_addr, 32'd0);
    check("mid_rst_data", o_imem_data, 32'd0);
    check("mid_rst_count", {16'd0, o_count}, 32'd0);
    check("mid_rst_err", {31'd0, o_error}, 32'd0);
`ifdef ENC_CHECKSUM_EN
    check("mid_rst_checksum", o_checksum, 32'd0);
`endif
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("post_rst_idle", {31'd0, o_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
